bcd_time_keeper: RTL

- Time-of-day source for the alarm clock: 1 Hz divider plus BCD seconds/minutes/hours counters, with a key-driven set mode.
- Drives the Hour/Minute bus consumed directly by the hourly chime stage (hourly chime = Light pulses on the hour), plus the display and alarm compare.
- Emits a one-cycle HourChime strobe on each natural hour rollover.

---
 rtl/bcd_time_keeper.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bcd_time_keeper.sv
// bcd_time_keeper: time-of-day source (1 Hz divider plus BCD hh:mm:ss) with a ModeKey/UpKey set mode.
// Latency: every output is registered. Second, SecPulse and carries update on the edge where the divider reaches its terminal count.
// Backpressure: none. Key inputs are single-cycle pulses that are always accepted, and ModeKey takes priority over UpKey.
//
// Ports:
//   i_clk          system clock; all state changes on posedge
//   i_reset        synchronous active-high reset; overrides every other input
//   i_mode_key     one-cycle pulse; steps RUN -> SET_HOUR -> SET_MINUTE -> RUN
//   i_up_key       one-cycle pulse; increments the field being edited
//   o_hour         BCD hours 00..23
//   o_minute       BCD minutes 00..59
//   o_second       BCD seconds 00..59
//   o_mode         0 RUN, 1 SET_HOUR, 2 SET_MINUTE
//   o_sec_pulse    one-cycle strobe when o_second shows a new value
//   o_hour_chime   one-cycle strobe when o_minute wraps 59->00 by carry in RUN

module bcd_time_keeper #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int DIV_W         = 26
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_mode_key,
    input  logic       i_up_key,
    output logic [7:0] o_hour,
    output logic [7:0] o_minute,
    output logic [7:0] o_second,
    output logic [1:0] o_mode,
    output logic       o_sec_pulse,
    output logic       o_hour_chime
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        SET_HOUR   = 2'd1,
        SET_MINUTE = 2'd2
    } mode_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICKS_PER_SEC - 1);

    mode_t            r_mode;
    logic [DIV_W-1:0] r_div;
    logic [7:0]       r_hour;
    logic [7:0]       r_minute;
    logic [7:0]       r_second;
    logic             r_sec_pulse;
    logic             r_hour_chime;

    // BCD increment with wrap at 'last'. A units nibble of 9 or more is treated
    // as 9 so that a corrupted nibble still steps back into legal BCD.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        logic [7:0] r;
        if (v == last) begin
            r = 8'h00;
        end else if (v[3:0] >= 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    logic       w_tick;
    logic       w_sec_wrap;
    logic       w_min_wrap;
    logic [7:0] w_second_inc;
    logic [7:0] w_minute_inc;
    logic [7:0] w_hour_inc;

    always_comb begin
        w_tick       = (r_div == DIV_LAST);
        w_sec_wrap   = (r_second == 8'h59);
        w_min_wrap   = (r_minute == 8'h59);
        w_second_inc = bcd_inc(r_second, 8'h59);
        w_minute_inc = bcd_inc(r_minute, 8'h59);
        w_hour_inc   = bcd_inc(r_hour, 8'h23);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mode       <= RUN;
            r_div        <= '0;
            r_hour       <= 8'h00;
            r_minute     <= 8'h00;
            r_second     <= 8'h00;
            r_sec_pulse  <= 1'b0;
            r_hour_chime <= 1'b0;
        end else begin
            // Strobes default low; only a RUN-mode tick raises them.
            r_sec_pulse  <= 1'b0;
            r_hour_chime <= 1'b0;
            case (r_mode)
                RUN: begin
                    if (i_mode_key) begin
                        // Divider and Second hold their values while the user edits.
                        r_mode <= SET_HOUR;
                    end else if (w_tick) begin
                        r_div       <= '0;
                        r_sec_pulse <= 1'b1;
                        r_second    <= w_second_inc;
                        if (w_sec_wrap) begin
                            r_minute <= w_minute_inc;
                            if (w_min_wrap) begin
                                r_hour       <= w_hour_inc;
                                r_hour_chime <= 1'b1;
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                SET_HOUR: begin
                    if (i_mode_key) begin
                        r_mode <= SET_MINUTE;
                    end else if (i_up_key) begin
                        r_hour <= w_hour_inc;
                    end
                end
                SET_MINUTE: begin
                    if (i_mode_key) begin
                        // Restart the second on leaving set mode so the first
                        // SecPulse lands a full second later.
                        r_mode   <= RUN;
                        r_second <= 8'h00;
                        r_div    <= '0;
                    end else if (i_up_key) begin
                        // Minute edits wrap locally and never carry into Hour.
                        r_minute <= w_minute_inc;
                    end
                end
                default: begin
                    r_mode <= RUN;
                end
            endcase
        end
    end

    assign o_hour       = r_hour;
    assign o_minute     = r_minute;
    assign o_second     = r_second;
    assign o_mode       = r_mode;
    assign o_sec_pulse  = r_sec_pulse;
    assign o_hour_chime = r_hour_chime;

endmodule
